// File: rtl/pipeline_mem_sequencer.sv
// Memory-stage sequencer for the 5-stage pipeline: runs each EX/MEM load/store through a
// req/ack data memory, freezes the pipe while the access is in flight, and raises load-use and branch controls.
module pipeline_mem_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [31:0] ALU_OUT_MEM,
    input  logic [31:0] REG_DATA2_MEM_FINAL,
    input  logic        Branch_MEM,
    input  logic        Zero_MEM,
    input  logic        MemRead_EX,
    input  logic [4:0]  RD_EX,
    input  logic [4:0]  RS1_ID,
    input  logic [4:0]  RS2_ID,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        stall_pipe,
    output logic        bubble_wb,
    output logic        hold_front,
    output logic        bubble_ex,
    output logic        flush_front,
    output logic        timeout_err,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] wait_cnt;
    logic       mem_op;
    logic       in_access;
    logic       acked;
    logic       timed_out;
    logic       stall_raw;
    logic       branch_taken;
    logic       load_use;

    assign mem_op    = MemRead_MEM | MemWrite_MEM;
    assign in_access = (state == S_ACCESS);
    assign acked     = in_access & dmem_ack;
    // Ack wins over a timeout landing in the same cycle.
    assign timed_out = in_access & ~dmem_ack & (wait_cnt == LAST_WAIT);

    assign stall_raw    = ((state == S_IDLE) & mem_op) | in_access;
    assign branch_taken = Branch_MEM & Zero_MEM;
    assign load_use     = MemRead_EX & (RD_EX != 5'd0) &
                          ((RD_EX == RS1_ID) | (RD_EX == RS2_ID));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (mem_op) state_next = S_ACCESS;
            S_ACCESS: if (acked || timed_out) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Pass-through and combinational controls are all held at 0 while reset is high.
    assign stall_pipe  = ~reset & stall_raw;
    assign bubble_wb   = stall_pipe;
    assign flush_front = ~reset & branch_taken & ~stall_raw;
    assign hold_front  = ~reset & load_use & ~stall_raw & ~branch_taken;
    assign bubble_ex   = hold_front;
    assign dmem_we     = ~reset & MemWrite_MEM;
    assign dmem_addr   = reset ? 32'd0 : ALU_OUT_MEM;
    assign dmem_wdata  = reset ? 32'd0 : REG_DATA2_MEM_FINAL;

    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= 8'd0;
            dmem_req     <= 1'b0;
            load_data    <= 32'd0;
            timeout_err  <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state    <= state_next;
            dmem_req <= (state_next == S_ACCESS);
            // Zero outside ACCESS, so every access starts counting from 0.
            wait_cnt <= in_access ? wait_cnt + 8'd1 : 8'd0;
            if (acked) begin
                load_data <= dmem_rdata;
            end else if (timed_out) begin
                load_data   <= 32'd0;
                timeout_err <= 1'b1;
            end
            if (stall_pipe) stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_mem_sequencer.sv
// Self-checking bench for pipeline_mem_sequencer: hazard vector table, directed memory
// sequences and randomized transactions against a transaction-level model.
module tb_pipeline_mem_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_MEM, MemWrite_MEM;
    logic [31:0] ALU_OUT_MEM, REG_DATA2_MEM_FINAL;
    logic        Branch_MEM, Zero_MEM, MemRead_EX;
    logic [4:0]  RD_EX, RS1_ID, RS2_ID;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data, stall_cycles;
    logic        stall_pipe, bubble_wb, hold_front, bubble_ex, flush_front, timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: counters expected at the start of the current cycle.
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_load  = 32'd0;
    logic        m_terr  = 1'b0;

    always #5 clk = ~clk;

    pipeline_mem_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .ALU_OUT_MEM(ALU_OUT_MEM), .REG_DATA2_MEM_FINAL(REG_DATA2_MEM_FINAL),
        .Branch_MEM(Branch_MEM), .Zero_MEM(Zero_MEM),
        .MemRead_EX(MemRead_EX), .RD_EX(RD_EX), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .load_data(load_data),
        .stall_pipe(stall_pipe), .bubble_wb(bubble_wb), .hold_front(hold_front),
        .bubble_ex(bubble_ex), .flush_front(flush_front), .timeout_err(timeout_err),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic       mrex;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       z;
        logic       exp_hold;
        logic       exp_flush;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
        ALU_OUT_MEM = 32'd0; REG_DATA2_MEM_FINAL = 32'd0;
        Branch_MEM = 1'b0; Zero_MEM = 1'b0; MemRead_EX = 1'b0;
        RD_EX = 5'd0; RS1_ID = 5'd0; RS2_ID = 5'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic rand_front();
        MemRead_EX = 1'($urandom_range(0, 1));
        RD_EX      = 5'($urandom_range(0, 3));
        RS1_ID     = 5'($urandom_range(0, 3));
        RS2_ID     = 5'($urandom_range(0, 3));
        Branch_MEM = 1'($urandom_range(0, 1));
        Zero_MEM   = 1'($urandom_range(0, 1));
    endtask

    // Front-end controls derived from the hazard rules and the expected memory stall.
    task automatic check_front(input logic exp_stall);
        logic lu, fl;
        lu = MemRead_EX && (RD_EX != 5'd0) && ((RD_EX == RS1_ID) || (RD_EX == RS2_ID));
        fl = Branch_MEM && Zero_MEM && !exp_stall;
        check("stall_pipe", {31'd0, stall_pipe}, {31'd0, exp_stall});
        check("bubble_wb", {31'd0, bubble_wb}, {31'd0, exp_stall});
        check("flush_front", {31'd0, flush_front}, {31'd0, fl});
        check("hold_front", {31'd0, hold_front}, {31'd0, lu && !exp_stall && !fl});
        check("bubble_ex", {31'd0, bubble_ex}, {31'd0, lu && !exp_stall && !fl});
    endtask

    task automatic check_regs();
        check("stall_cycles", stall_cycles, m_stall);
        check("load_data", load_data, m_load);
        check("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
    endtask

    task automatic idle_cycle(input bit rnd);
        @(negedge clk);
        clear_inputs();
        if (rnd) begin
            rand_front();
            dmem_ack   = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
        end
        #1;
        check_front(1'b0);
        check("dmem_req idle", {31'd0, dmem_req}, 32'd0);
        check_regs();
    endtask

    // One memory op; ack_at is the 1-based ACCESS cycle carrying the ack, outside 1..TO means none.
    task automatic run_op(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rd, input bit rnd,
                          output int req_cnt);
        int  a;
        bit  hit;
        hit     = (ack_at >= 1) && (ack_at <= TO);
        a       = hit ? ack_at : TO;
        req_cnt = 0;
        for (int c = 0; c <= a + 1; c++) begin
            @(negedge clk);
            clear_inputs();
            MemRead_MEM = !st; MemWrite_MEM = st;
            ALU_OUT_MEM = addr; REG_DATA2_MEM_FINAL = wd;
            if (rnd) rand_front();
            if (c >= 1 && c <= a) begin
                dmem_ack   = (c == ack_at);
                dmem_rdata = (c == ack_at) ? rd : $urandom;
            end else begin
                dmem_ack   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                dmem_rdata = $urandom;
            end
            #1;
            check_front(c <= a);
            check("dmem_req", {31'd0, dmem_req}, {31'd0, (c >= 1 && c <= a)});
            if (c >= 1 && c <= a) begin
                check("dmem_we", {31'd0, dmem_we}, {31'd0, st});
                check("dmem_addr", dmem_addr, addr);
                check("dmem_wdata", dmem_wdata, wd);
            end
            req_cnt += int'(dmem_req);
            check_regs();
            if (c <= a) m_stall++;
            if (c == a) begin
                m_load = hit ? rd : 32'd0;
                if (!hit) m_terr = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   rq;

        vecs = '{
            '{1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}
        };

        // Reset with every input active: combinational outputs must read 0.
        clear_inputs();
        reset = 1'b1;
        MemRead_MEM = 1'b1; MemWrite_MEM = 1'b1; ALU_OUT_MEM = 32'hFFFF_0000;
        REG_DATA2_MEM_FINAL = 32'hA5A5_A5A5; Branch_MEM = 1'b1; Zero_MEM = 1'b1;
        MemRead_EX = 1'b1; RD_EX = 5'd5; RS2_ID = 5'd5; dmem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst stall_pipe", {31'd0, stall_pipe}, 32'd0);
        check("rst flush_front", {31'd0, flush_front}, 32'd0);
        check("rst hold_front", {31'd0, hold_front}, 32'd0);
        check("rst dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst dmem_addr", dmem_addr, 32'd0);
        check("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        check_regs();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;

        // Hazard table in IDLE with no memory op.
        foreach (vecs[i]) begin
            @(negedge clk);
            clear_inputs();
            MemRead_EX = vecs[i].mrex; RD_EX = vecs[i].rd;
            RS1_ID = vecs[i].rs1; RS2_ID = vecs[i].rs2;
            Branch_MEM = vecs[i].br; Zero_MEM = vecs[i].z;
            #1;
            check($sformatf("vec%0d hold_front", i), {31'd0, hold_front}, {31'd0, vecs[i].exp_hold});
            check($sformatf("vec%0d bubble_ex", i), {31'd0, bubble_ex}, {31'd0, vecs[i].exp_hold});
            check($sformatf("vec%0d flush_front", i), {31'd0, flush_front}, {31'd0, vecs[i].exp_flush});
            check($sformatf("vec%0d stall_pipe", i), {31'd0, stall_pipe}, 32'd0);
        end

        // Load, zero-wait memory.
        run_op(1'b0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, rq);
        check("load0 req cycles", rq, 1);
        check("load0 load_data", load_data, 32'hDEAD_BEEF);
        check("load0 stall_cycles", stall_cycles, 32'd2);
        idle_cycle(1'b0);

        // Store with 3 wait states; the ack lands in the timeout cycle and must win.
        run_op(1'b1, 32'h40, 32'h1234_5678, 4, 32'h0BAD_F00D, 1'b0, rq);
        check("store3 req cycles", rq, 4);
        check("store3 stall_cycles", stall_cycles, 32'd7);
        check("store3 timeout_err", {31'd0, timeout_err}, 32'd0);

        // Timeout without ack, then a normal load right behind it.
        run_op(1'b0, 32'h80, 32'h0, 0, 32'h0, 1'b0, rq);
        check("timeout req cycles", rq, 4);
        check("timeout flag", {31'd0, timeout_err}, 32'd1);
        check("timeout load_data", load_data, 32'd0);
        run_op(1'b0, 32'h84, 32'h0, 2, 32'hCAFE_0001, 1'b0, rq);
        check("after-timeout load_data", load_data, 32'hCAFE_0001);
        check("timeout sticky", {31'd0, timeout_err}, 32'd1);
        idle_cycle(1'b0);

        // Reset in the second ACCESS cycle, late ack afterwards.
        @(negedge clk); clear_inputs(); MemRead_MEM = 1'b1; ALU_OUT_MEM = 32'h200;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        check("midrst stall_pipe", {31'd0, stall_pipe}, 32'd0);
        @(negedge clk);
        reset = 1'b0; MemRead_MEM = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        #1;
        check("midrst dmem_req", {31'd0, dmem_req}, 32'd0);
        check("midrst stall_cycles", stall_cycles, 32'd0);
        @(negedge clk); dmem_ack = 1'b0;
        #1;
        check("late ack load_data", load_data, 32'd0);
        check("late ack dmem_req", {31'd0, dmem_req}, 32'd0);
        check("late ack timeout_err", {31'd0, timeout_err}, 32'd0);
        m_stall = 32'd0; m_load = 32'd0; m_terr = 1'b0;

        // Randomized transactions with random hazards, spurious acks and gaps.
        for (int n = 0; n < 60; n++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, $urandom,
                   int'($urandom_range(0, TO + 2)), $urandom, 1'b1, rq);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
